fp_decode_serial: RTL and testbench

Iterative floating-point-to-linear decoder: accepts an 8-bit compressed value (sign S, 3-bit exponent E, 4-bit significand F) and reconstructs the 12-bit two's-complement linear value D = (−1)^S · F · 2^E. It is the inverse of the team's linear-to-float encoder/rounder and sits on the playback side of the datapath, between the compressed-sample store and any linear consumer. The magnitude is expanded by one left shift per cycle under a small FSM, with valid/ready handshakes on both sides.

---
 rtl/fp_pkg.sv | 21 ++
 rtl/fp_dec_datapath.sv | 49 ++++
 rtl/fp_decode_serial.sv | 81 ++++++++
 tb/tb_fp_decode_serial.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared float-format definitions for the linear/float encoder and decoder.
// Holds the default field widths, the packed float word and decoder states.
package fp_pkg;

  localparam int EXP_W = 3;
  localparam int SIG_W = 4;
  localparam int LIN_W = 12;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [SIG_W-1:0] f;
  } fp_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } fp_dec_state_t;

endpackage

// File: rtl/fp_dec_datapath.sv
// Decoder datapath: magnitude shift register, exponent down-counter
// and the sign-apply stage feeding the held result register.
module fp_dec_datapath
  import fp_pkg::*;
#(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int SIG_W = fp_pkg::SIG_W,
  parameter int LIN_W = fp_pkg::LIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             s,
  input  logic [EXP_W-1:0] e,
  input  logic [SIG_W-1:0] f,
  output logic             last,
  output logic [LIN_W-1:0] d
);

  logic [LIN_W-1:0] mag;
  logic [EXP_W-1:0] cnt;
  logic             sgn;

  // Shifting is finished once the exponent counter has drained.
  assign last = (cnt == '0);

  // Load on accept, one shift per step, then apply sign into d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      d   <= '0;
    end else if (load) begin
      mag <= LIN_W'(f);
      cnt <= e;
      sgn <= s;
    end else if (step) begin
      if (!last) begin
        mag <= mag << 1;
        cnt <= cnt - 1'b1;
      end else begin
        d <= sgn ? (~mag + 1'b1) : mag;
      end
    end
  end

endmodule

// File: rtl/fp_decode_serial.sv
// Iterative float-to-linear decoder: D = (-1)^S * F * 2^E,
// one left shift per cycle, valid/ready on both sides.
module fp_decode_serial
  import fp_pkg::*;
#(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int SIG_W = fp_pkg::SIG_W,
  parameter int LIN_W = fp_pkg::LIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s,
  input  logic [EXP_W-1:0] e,
  input  logic [SIG_W-1:0] f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LIN_W-1:0] d,
  output logic             busy
);

  if (LIN_W < SIG_W + (1 << EXP_W)) begin : g_width_check
    $error("LIN_W too narrow for SIG_W + 2^EXP_W");
  end

  fp_dec_state_t state, state_nx;
  logic          load;
  logic          step;
  logic          last;

  assign load = (state == ST_IDLE) && in_valid;
  assign step = (state == ST_SHIFT);

  fp_dec_datapath #(
    .EXP_W(EXP_W),
    .SIG_W(SIG_W),
    .LIN_W(LIN_W)
  ) u_dp (
    .clk (clk),
    .rst (rst),
    .load(load),
    .step(step),
    .s   (s),
    .e   (e),
    .f   (f),
    .last(last),
    .d   (d)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (in_valid)  state_nx = ST_SHIFT;
      ST_SHIFT: if (last)      state_nx = ST_DONE;
      ST_DONE:  if (out_ready) state_nx = ST_IDLE;
      default:                 state_nx = ST_IDLE;
    endcase
  end

  // Registered handshake/status outputs, decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_nx == ST_IDLE);
      out_valid <= (state_nx == ST_DONE);
      busy      <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_fp_decode_serial.sv
// Self-checking bench for fp_decode_serial: directed cases plus
// randomized conversions against an arithmetic reference model.
module tb_fp_decode_serial;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        s;
  logic [2:0]  e;
  logic [3:0]  f;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] d;
  logic        busy;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  fp_decode_serial dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s        (s),
    .e        (e),
    .f        (f),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d        (d),
    .busy     (busy)
  );

  function automatic logic [11:0] ref_d(bit rs, int re, int rf);
    int v;
    v = rf * (2 ** re);
    if (rs) v = -v;
    return 12'(v);
  endfunction

  task automatic check(string tag, int obs, int exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                tag, obs, obs, exp, exp);
  endtask

  // One conversion: accept, measure latency, hold, handshake.
  task automatic conv(bit cs, int ce, int cf, int hold,
                      bit scram, bit pre_rdy, bit jam);
    logic [11:0] exp_d;
    int          lat;
    int          w;
    exp_d = ref_d(cs, ce, cf);
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_accept", int'(in_ready), 1);
    in_valid  = 1'b1;
    s         = cs;
    e         = 3'(ce);
    f         = 4'(cf);
    out_ready = pre_rdy;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (scram) begin
        s = 1'($urandom);
        e = 3'($urandom);
        f = 4'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    check("latency", lat, ce + 1);
    check("d_value", int'(d), int'(exp_d));
    check("in_ready_done", int'(in_ready), 0);
    check("busy_done", int'(busy), 1);
    if (pre_rdy) begin
      @(posedge clk);
      #1;
    end else begin
      for (int i = 0; i < hold; i++) begin
        in_valid = jam;
        @(posedge clk);
        #1;
        check("hold_valid", int'(out_valid), 1);
        check("hold_d", int'(d), int'(exp_d));
        check("hold_in_ready", int'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    check("post_valid", int'(out_valid), 0);
    check("post_in_ready", int'(in_ready), 1);
    check("post_busy", int'(busy), 0);
    check("post_d_kept", int'(d), int'(exp_d));
  endtask

  initial begin
    fp_word_t w;
    int       rose;
    rst       = 1'b1;
    in_valid  = 1'b1;
    s         = 1'b0;
    e         = '0;
    f         = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_d", int'(d), 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;

    conv(0, 0, 7, 0, 0, 0, 0);
    conv(0, 7, 15, 1, 0, 0, 0);
    conv(1, 7, 15, 0, 0, 0, 0);
    conv(1, 2, 14, 2, 0, 0, 0);
    conv(1, 5, 0, 0, 0, 0, 0);
    conv(0, 3, 5, 10, 0, 0, 1);
    conv(0, 4, 9, 0, 1, 0, 0);
    conv(1, 6, 11, 0, 0, 1, 0);

    @(negedge clk);
    in_valid = 1'b1;
    s        = 1'b0;
    e        = 3'd6;
    f        = 4'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_d", int'(d), 0);
    @(negedge clk);
    rst  = 1'b0;
    rose = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) rose = 1;
    end
    check("midrst_no_valid", rose, 0);
    conv(0, 1, 15, 0, 0, 0, 0);

    for (int k = 0; k < 24; k++) begin
      w = fp_word_t'($urandom);
      conv(w.s, int'(w.e), int'(w.f), int'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
